// File: rtl/uart_rx_mmio_pkg.sv
// rtl/uart_rx_mmio_pkg.sv - shared register map, status layout and receiver state encoding
package uart_rx_mmio_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int ST_NONEMPTY  = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_COUNT_W   = 6;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - byte-wide synchronous RX FIFO, head byte visible combinationally
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [7:0]                    din,
  output logic [7:0]                    dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// rtl/uart_rx_mmio.sv - 8N1 UART receiver feeding an RX FIFO behind a two-word load/store interface
module uart_rx_mmio
  import uart_rx_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        CLK100MHZ,
  input  logic        rst_n,
  input  logic        uart_txd_in,
  input  logic        sel,
  input  logic        rd,
  input  logic        wr,
  input  logic        addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        irq
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta, rx_sync;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          brk_q, brk_d;
  logic          push_q, push_d;
  logic          ferr_evt;
  logic          cnt_zero;

  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_count;

  logic          rd_en, wr_en, pop, pop_eff, ovr_evt, clr_ovr, clr_ferr;
  logic          overrun, frame_err;
  logic [31:0]   status_w;
  logic          unused_wdata;

  assign unused_wdata = ^{wdata[31:4], wdata[1:0]};

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_txd_in;
      rx_sync <= rx_meta;
    end
  end

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      brk_q   <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      brk_q   <= brk_d;
      push_q  <= push_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    brk_d    = brk_q;
    push_d   = 1'b0;
    ferr_evt = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_sync) begin
          state_d = RX_START;
          cnt_d   = CNT_HALF;
        end
      end
      RX_START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rx_sync) begin
          state_d = RX_DATA;
          cnt_d   = CNT_FULL;
          idx_d   = 3'd0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d[idx_q] = rx_sync;
          cnt_d          = CNT_FULL;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // After a bad stop bit, park here until the line idles so a break is one error.
        if (brk_q) begin
          if (rx_sync) begin
            brk_d   = 1'b0;
            state_d = RX_IDLE;
          end
        end else if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_sync) begin
          push_d  = 1'b1;
          state_d = RX_IDLE;
        end else begin
          ferr_evt = 1'b1;
          brk_d    = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rd_en    = sel & rd;
  assign wr_en    = sel & wr & ~rd;
  assign pop      = rd_en & (addr == ADDR_DATA);
  assign pop_eff  = pop & ~fifo_empty;
  assign ovr_evt  = push_q & fifo_full & ~pop_eff;
  assign clr_ovr  = wr_en & (addr == ADDR_STATUS) & wdata[ST_OVERRUN];
  assign clr_ferr = wr_en & (addr == ADDR_STATUS) & wdata[ST_FRAME_ERR];

  uart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK100MHZ),
    .rst_n (rst_n),
    .push  (push_q),
    .pop   (pop),
    .din   (shift_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status_w                                = '0;
    status_w[ST_NONEMPTY]                   = ~fifo_empty;
    status_w[ST_FULL]                       = fifo_full;
    status_w[ST_OVERRUN]                    = overrun;
    status_w[ST_FRAME_ERR]                  = frame_err;
    status_w[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(fifo_count);
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      irq       <= 1'b0;
    end else begin
      overrun   <= (overrun & ~clr_ovr) | ovr_evt;
      frame_err <= (frame_err & ~clr_ferr) | ferr_evt;
      rvalid    <= rd_en;
      irq       <= ~fifo_empty;
      if (rd_en) begin
        if (addr == ADDR_STATUS) rdata <= status_w;
        else                     rdata <= {24'b0, fifo_empty ? 8'h00 : fifo_dout};
      end
    end
  end

endmodule
